// File: rtl/logic_arb32.sv
// Two-port round-robin arbiter/sequencer for the shared 32-bit logic unit.
// Optional Zero result flag enabled by defining LOGIC_ARB_ZERO_FLAG_EN.
module logic_arb32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ReqValid,
    output logic [1:0]  ReqReady,
    input  logic [1:0]  OpA,
    input  logic [1:0]  OpB,
    input  logic [31:0] In1A,
    input  logic [31:0] In2A,
    input  logic [31:0] In1B,
    input  logic [31:0] In2B,
    output logic [31:0] AluIn1,
    output logic [31:0] AluIn2,
    output logic [1:0]  AluOp,
    input  logic [31:0] AluOut,
    output logic [1:0]  RspValid,
    input  logic [1:0]  RspReady,
    output logic [31:0] Out,
    output logic        Busy,
    output logic [1:0]  dbg_state
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    ,
    output logic        Zero
`endif
);

    // Handshakes: a request transfers in a cycle where ReqValid[i] and ReqReady[i]
    // are both high; a response transfers when RspValid[i] and RspReady[i] are high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   prio;
    logic   gnt;
    logic   pick;

    // A lone requester wins outright; contention is settled by the pointer.
    always_comb begin
        pick = prio;
        if (ReqValid == 2'b01) begin
            pick = 1'b0;
        end else if (ReqValid == 2'b10) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        ReqReady = 2'b00;
        if (state == IDLE && ReqValid != 2'b00) begin
            ReqReady = pick ? 2'b10 : 2'b01;
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            gnt      <= 1'b0;
            AluIn1   <= 32'h0;
            AluIn2   <= 32'h0;
            AluOp    <= 2'b00;
            Out      <= 32'h0;
            RspValid <= 2'b00;
            Busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid != 2'b00) begin
                        gnt    <= pick;
                        AluOp  <= pick ? OpB  : OpA;
                        AluIn1 <= pick ? In1B : In1A;
                        AluIn2 <= pick ? In2B : In2A;
                        Busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    Out      <= AluOut;
                    RspValid <= gnt ? 2'b10 : 2'b01;
                    state    <= RESP;
                end
                RESP: begin
                    if (RspReady[gnt]) begin
                        RspValid <= 2'b00;
                        Busy     <= 1'b0;
                        prio     <= ~gnt;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LOGIC_ARB_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            Zero <= 1'b0;
        end else if (state == EXEC) begin
            Zero <= (AluOut == 32'h0);
        end
    end
`endif

endmodule

// File: tb/tb_logic_arb32.sv
// Directed bench for logic_arb32 with a behavioural model of the shared logic unit.
// Zero flag checks compile in when LOGIC_ARB_ZERO_FLAG_EN is defined.
module tb_logic_arb32;

    logic        clk;
    logic        rst;
    logic [1:0]  ReqValid;
    logic [1:0]  ReqReady;
    logic [1:0]  OpA, OpB;
    logic [31:0] In1A, In2A, In1B, In2B;
    logic [31:0] AluIn1, AluIn2;
    logic [1:0]  AluOp;
    logic [31:0] AluOut;
    logic [1:0]  RspValid;
    logic [1:0]  RspReady;
    logic [31:0] Out;
    logic        Busy;
    logic [1:0]  dbg_state;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic        Zero;
`endif

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];

    logic_arb32 dut (
        .clk(clk), .rst(rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .OpA(OpA), .OpB(OpB),
        .In1A(In1A), .In2A(In2A), .In1B(In1B), .In2B(In2B),
        .AluIn1(AluIn1), .AluIn2(AluIn2), .AluOp(AluOp), .AluOut(AluOut),
        .RspValid(RspValid), .RspReady(RspReady),
        .Out(Out), .Busy(Busy), .dbg_state(dbg_state)
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        , .Zero(Zero)
`endif
    );

    // Shared logic unit
    always_comb begin
        case (AluOp)
            2'b00:   AluOut = AluIn1 & AluIn2;
            2'b01:   AluOut = AluIn1 | AluIn2;
            2'b10:   AluOut = AluIn1 ^ AluIn2;
            default: AluOut = ~(AluIn1 | AluIn2);
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        ReqValid = 2'b00;
        RspReady = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for a grant to port, step through EXEC, check the response, accept it.
    task automatic serve(input int port, input bit clear, input int exp_wait, input string tag);
        int          w;
        logic [1:0]  onehot;
        logic [31:0] e;
        onehot = (port == 0) ? 2'b01 : 2'b10;
        w = 0;
        @(negedge clk);
        while (ReqReady == 2'b00 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_vec({tag, " grant_wait"}, w, exp_wait);
        check_vec({tag, " ReqReady"}, {30'd0, ReqReady}, {30'd0, onehot});
        tick();
        if (clear) ReqValid[port] = 1'b0;
        w = 0;
        @(negedge clk);
        while (RspValid == 2'b00 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_vec({tag, " rsp_latency"}, w, 1);
        check_vec({tag, " RspValid"}, {30'd0, RspValid}, {30'd0, onehot});
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check_vec({tag, " Out"}, Out, e);
        RspReady = onehot;
        tick();
        RspReady = 2'b00;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        ReqValid = 2'b00;
        RspReady = 2'b00;
        OpA = 2'b00; OpB = 2'b00;
        In1A = 32'h0; In2A = 32'h0; In1B = 32'h0; In2B = 32'h0;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_vec("rst Busy", {31'd0, Busy}, 32'd0);
        check_vec("rst RspValid", {30'd0, RspValid}, 32'd0);
        check_vec("rst ReqReady", {30'd0, ReqReady}, 32'd0);
        check_vec("rst Out", Out, 32'h0);
        check_vec("rst AluIn1", AluIn1, 32'h0);
        check_vec("rst AluIn2", AluIn2, 32'h0);
        check_vec("rst AluOp", {30'd0, AluOp}, 32'd0);
        check_vec("rst state", {30'd0, dbg_state}, 32'd0);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        check_vec("rst Zero", {31'd0, Zero}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // A alone: AND
        OpA = 2'b00; In1A = 32'hFFFF0000; In2A = 32'h0F0F0F0F;
        ReqValid = 2'b01;
        exp_q.push_back(32'h0F0F0000);
        serve(0, 1'b1, 0, "t1_a");

        // Simultaneous after reset: A wins, then B
        apply_reset();
        OpA = 2'b01; In1A = 32'h000000F0; In2A = 32'h0000000F;
        OpB = 2'b10; In1B = 32'hAAAAAAAA; In2B = 32'hFFFFFFFF;
        ReqValid = 2'b11;
        exp_q.push_back(32'h000000FF);
        exp_q.push_back(32'h55555555);
        serve(0, 1'b1, 0, "t2_a");
        serve(1, 1'b1, 0, "t2_b");

        // Back-to-back contention alternates A, B, A, B at a 3-cycle interval
        apply_reset();
        OpA = 2'b00; In1A = 32'hFFFFFFFF; In2A = 32'h12345678;
        OpB = 2'b01; In1B = 32'h00FF0000; In2B = 32'h000000FF;
        ReqValid = 2'b11;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h00FF00FF);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h00FF00FF);
        serve(0, 1'b0, 0, "t3_a0");
        serve(1, 1'b0, 0, "t3_b0");
        serve(0, 1'b0, 0, "t3_a1");
        serve(1, 1'b0, 0, "t3_b1");
        ReqValid = 2'b00;

        // B NOR with a stalled response while A waits
        OpB = 2'b11; In1B = 32'h0; In2B = 32'h0;
        OpA = 2'b00; In1A = 32'hFFFF0000; In2A = 32'h0F0F0F0F;
        ReqValid = 2'b10;
        exp_q.push_back(32'hFFFFFFFF);
        exp_q.push_back(32'h0F0F0000);
        @(negedge clk);
        check_vec("t4 grant_b", {30'd0, ReqReady}, 32'd2);
        tick();
        ReqValid = 2'b01;
        RspReady = 2'b01;
        @(negedge clk);
        check_vec("t4 exec ReqReady", {30'd0, ReqReady}, 32'd0);
        check_vec("t4 exec AluOp", {30'd0, AluOp}, 32'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_vec("t4 stall RspValid", {30'd0, RspValid}, 32'd2);
            check_vec("t4 stall Out", Out, 32'hFFFFFFFF);
            check_vec("t4 stall ReqReady", {30'd0, ReqReady}, 32'd0);
            check_vec("t4 stall Busy", {31'd0, Busy}, 32'd1);
            tick();
        end
        RspReady = 2'b10;
        @(negedge clk);
        check_vec("t4 rsp RspValid", {30'd0, RspValid}, 32'd2);
        check_vec("t4 rsp Out", Out, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF);
        tick();
        RspReady = 2'b00;
        serve(0, 1'b1, 0, "t4_a");

        // Reset during EXEC aborts the transaction
        apply_reset();
        OpA = 2'b01; In1A = 32'h1; In2A = 32'h2;
        ReqValid = 2'b01;
        @(negedge clk);
        check_vec("t5 grant_a", {30'd0, ReqReady}, 32'd1);
        tick();
        ReqValid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_vec("t5 Busy", {31'd0, Busy}, 32'd0);
        check_vec("t5 Out", Out, 32'h0);
        check_vec("t5 AluIn1", AluIn1, 32'h0);
        check_vec("t5 state", {30'd0, dbg_state}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec("t5 no RspValid", {30'd0, RspValid}, 32'd0);
        end
        tick();
        OpA = 2'b10; In1A = 32'h0000FFFF; In2A = 32'hFFFFFFFF;
        ReqValid = 2'b01;
        exp_q.push_back(32'hFFFF0000);
        serve(0, 1'b1, 0, "t5_a");

        // Zero result, then a non-zero result from the same operands
        OpA = 2'b00; In1A = 32'hF0F0F0F0; In2A = 32'h0F0F0F0F;
        ReqValid = 2'b01;
        exp_q.push_back(32'h0);
        serve(0, 1'b1, 0, "t6_and");
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        check_vec("t6 Zero and", {31'd0, Zero}, 32'd1);
`endif
        OpA = 2'b01;
        ReqValid = 2'b01;
        exp_q.push_back(32'hFFFFFFFF);
        serve(0, 1'b1, 0, "t6_or");
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        check_vec("t6 Zero or", {31'd0, Zero}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
